// File: rtl/bunny_hit_gen.sv
// Collision detector for the bunny runner: one registered hit pulse per collision,
// followed by a tick-timed invulnerability window with sprite blink, until game over.
module bunny_hit_gen #(
    parameter int HIT_X_MIN      = 8,
    parameter int HIT_X_MAX      = 15,
    parameter int COOLDOWN_TICKS = 64,
    parameter int BLINK_DIV      = 8,
    parameter int MAX_HITS       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       restart,
    input  logic       die,
    input  logic [1:0] bunny_lane,
    input  logic       obs_valid,
    input  logic [1:0] obs_lane,
    input  logic [7:0] obs_x,
    output logic       hit,
    output logic       invuln,
    output logic       blink,
    output logic [1:0] hits_taken,
    output logic       dead
);

    localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);
    // A 1-bit blink counter stands in when BLINK_DIV is 1 (toggle on every tick).
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] ARMED    = 2'd0;
    localparam logic [1:0] HIT      = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;
    localparam logic [1:0] DEAD     = 2'd3;

    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_TICKS);
    localparam logic [CD_W-1:0] CD_ONE   = CD_W'(1);
    localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_DIV - 1);
    localparam logic [BL_W-1:0] BL_ONE   = BL_W'(1);
    localparam logic [1:0]      HITS_MAX = 2'(MAX_HITS);
    localparam logic [7:0]      X_MIN    = 8'(HIT_X_MIN);
    localparam logic [7:0]      X_MAX    = 8'(HIT_X_MAX);

    logic [1:0]      state_r, state_s;
    logic [CD_W-1:0] cd_cnt_r, cd_cnt_s;
    logic [BL_W-1:0] blink_cnt_r, blink_cnt_s;
    logic            hit_r, hit_s;
    logic            invuln_r, invuln_s;
    logic            blink_r, blink_s;
    logic [1:0]      hits_r, hits_s;
    logic            dead_r, dead_s;
    logic            collide_s;

    // Overlap test, evaluated every clock regardless of tick.
    always_comb begin
        collide_s = obs_valid && (obs_lane == bunny_lane) &&
                    (obs_x >= X_MIN) && (obs_x <= X_MAX);
    end

    // Next-state and next-output logic; restart overrides everything.
    always_comb begin
        state_s     = state_r;
        cd_cnt_s    = cd_cnt_r;
        blink_cnt_s = blink_cnt_r;
        hit_s       = 1'b0;
        invuln_s    = invuln_r;
        blink_s     = blink_r;
        hits_s      = hits_r;
        dead_s      = dead_r;
        if (restart) begin
            state_s     = ARMED;
            cd_cnt_s    = '0;
            blink_cnt_s = '0;
            invuln_s    = 1'b0;
            blink_s     = 1'b0;
            hits_s      = 2'd0;
            dead_s      = 1'b0;
        end else begin
            case (state_r)
                ARMED: begin
                    if (collide_s) begin
                        state_s = HIT;
                        hit_s   = 1'b1;
                        if (hits_r < HITS_MAX) begin
                            hits_s = hits_r + 2'd1;
                        end else begin
                            hits_s = hits_r;
                        end
                    end else if (die) begin
                        state_s = DEAD;
                        dead_s  = 1'b1;
                    end else begin
                        state_s = ARMED;
                    end
                end
                HIT: begin
                    // hits_r already holds the post-hit count here.
                    if ((hits_r == HITS_MAX) || die) begin
                        state_s = DEAD;
                        dead_s  = 1'b1;
                    end else begin
                        state_s     = COOLDOWN;
                        cd_cnt_s    = CD_LOAD;
                        blink_cnt_s = '0;
                        blink_s     = 1'b1;
                        invuln_s    = 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (die) begin
                        state_s     = DEAD;
                        dead_s      = 1'b1;
                        invuln_s    = 1'b0;
                        blink_s     = 1'b0;
                        cd_cnt_s    = '0;
                        blink_cnt_s = '0;
                    end else if (tick) begin
                        if (cd_cnt_r <= CD_ONE) begin
                            state_s     = ARMED;
                            invuln_s    = 1'b0;
                            blink_s     = 1'b0;
                            cd_cnt_s    = '0;
                            blink_cnt_s = '0;
                        end else begin
                            cd_cnt_s = cd_cnt_r - CD_ONE;
                            if (blink_cnt_r == BL_LAST) begin
                                blink_cnt_s = '0;
                                blink_s     = ~blink_r;
                            end else begin
                                blink_cnt_s = blink_cnt_r + BL_ONE;
                            end
                        end
                    end else begin
                        state_s = COOLDOWN;
                    end
                end
                DEAD: begin
                    state_s = DEAD;
                end
                default: begin
                    state_s     = ARMED;
                    cd_cnt_s    = '0;
                    blink_cnt_s = '0;
                    invuln_s    = 1'b0;
                    blink_s     = 1'b0;
                    dead_s      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ARMED;
            cd_cnt_r    <= '0;
            blink_cnt_r <= '0;
            hit_r       <= 1'b0;
            invuln_r    <= 1'b0;
            blink_r     <= 1'b0;
            hits_r      <= 2'd0;
            dead_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cd_cnt_r    <= cd_cnt_s;
            blink_cnt_r <= blink_cnt_s;
            hit_r       <= hit_s;
            invuln_r    <= invuln_s;
            blink_r     <= blink_s;
            hits_r      <= hits_s;
            dead_r      <= dead_s;
        end
    end

    assign hit        = hit_r;
    assign invuln     = invuln_r;
    assign blink      = blink_r;
    assign hits_taken = hits_r;
    assign dead       = dead_r;

endmodule
